prime_bench_ctrl: RTL and testbench
===================================

PRIME_BENCH_CTRL -- requirements
Module: prime_bench_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the prime/result width in bits (legal 4..32).
REQ-002 SHALL have parameter NLEDS, default 4, the number of progress LEDs (legal 1..8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a level input that begins a run when sampled high in IDLE.
REQ-006 SHALL have port limit, input, WIDTH, the primes to collect before stopping; 0 means unlimited.
REQ-007 SHALL have port pg_go, output, 1, the one-cycle request pulse to the prime generator.
REQ-008 SHALL have port pg_ready, input, 1, the generator-idle/result-valid flag.
REQ-009 SHALL have port pg_error, input, 1, the generator overflow flag, qualified by pg_ready.
REQ-010 SHALL have port pg_res, input, WIDTH, the generator result, valid when pg_ready=1.
REQ-011 SHALL have port prime, output, WIDTH, the last accepted prime.
REQ-012 SHALL have port count, output, WIDTH, the number of primes accepted this run.
REQ-013 SHALL have port cycles, output, 32, the elapsed run cycles.
REQ-014 SHALL have port leds, output, NLEDS, the registered thermometer progress bar.
REQ-015 SHALL have port done, output, 1, high while in DONE.
REQ-016 SHALL have port ovf, output, 1, high when the run ended on pg_error.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, GAP, WAIT and DONE.
REQ-018 IDLE SHALL go to ISSUE when start=1 and clear prime, count, cycles, leds and ovf in that same cycle.
REQ-019 ISSUE SHALL drive pg_go=1 for exactly one cycle and then go to GAP; pg_go SHALL be 0 in all other states.
REQ-020 GAP SHALL ignore pg_ready for one cycle, giving the generator time to register go, and then go to WAIT.
REQ-021 In WAIT with pg_ready=1 and pg_error=0, the block SHALL latch prime<=pg_res, increment count, and go to ISSUE.
REQ-022 If limit!=0 and the incremented count equals limit, REQ-021 SHALL go to DONE instead of ISSUE.
REQ-023 In WAIT with pg_ready=1 and pg_error=1, the block SHALL go to DONE with ovf<=1 and leave prime and count unchanged.
REQ-024 DONE SHALL hold all outputs and return to IDLE only when start=0; a start held high SHALL NOT restart a run.
REQ-025 count SHALL saturate at all-ones and never wrap, including when limit=0.
REQ-026 STEP SHALL equal ceil((2^WIDTH-1)/NLEDS), computed at elaboration without overflowing WIDTH+1 bits.
REQ-027 leds[k] SHALL be set to (prime > k*STEP) one cycle after prime updates, so leds lag prime by 1 cycle.
REQ-028 cycles SHALL increment every cycle outside IDLE and DONE and saturate at 2^32-1.
REQ-029 When pg_ready and start change in the same cycle, only the current FSM state SHALL decide which input is acted on.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pg_go=0, prime=0, count=0, cycles=0, leds=0, done=0 and ovf=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no further pg_go pulse; after release, a new run needs start=1.

Configuration
REQ-032 With macro PRIME_BENCH_CYCLES_EN defined, the cycles counter SHALL be built as specified in REQ-028.
REQ-033 Without PRIME_BENCH_CYCLES_EN, cycles SHALL be a constant 0 and no counter flops SHALL be inferred.

Verification (WIDTH=8, NLEDS=4, STEP=64, behavioural generator model)
REQ-034 Reset then start=1, limit=3, model returns 2,3,5 -> three pg_go pulses, prime=5, count=3, done=1, ovf=0.
REQ-035 limit=0, model steps through primes up to 251, then asserts pg_error -> done=1, ovf=1, prime=251, count=54, leds=4'b1111.
REQ-036 prime crosses 63->67 -> leds goes 4'b0001->4'b0011 exactly one cycle after prime updates.
REQ-037 Model holds pg_ready=1 throughout GAP -> no result is accepted in GAP; exactly one prime is accepted per pg_go.
REQ-038 rst_n pulsed low while in WAIT -> all outputs are 0 immediately; no pg_go pulse until the next start.
REQ-039 start held high through DONE -> block stays in DONE; start=0 then start=1 -> a new run begins with count=0.

Source files
------------

// File: rtl/prime_bench_ctrl.sv
// prime_bench_ctrl: sequences a prime generator, collects results and shows progress on LEDs.
// Define PRIME_BENCH_CYCLES_EN to build the elapsed-cycle counter; otherwise cycles reads 0.
module prime_bench_ctrl #(
    parameter int WIDTH = 16,
    parameter int NLEDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic             pg_go,
    input  logic             pg_ready,
    input  logic             pg_error,
    input  logic [WIDTH-1:0] pg_res,
    output logic [WIDTH-1:0] prime,
    output logic [WIDTH-1:0] count,
    output logic [31:0]      cycles,
    output logic [NLEDS-1:0] leds,
    output logic             done,
    output logic             ovf
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_t;
    // Thresholds are held in WIDTH+1 bits so k*STEP cannot wrap for WIDTH=32.
    localparam logic [WIDTH:0] MAXV = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP = (MAXV + (WIDTH+1)'(NLEDS - 1)) / (WIDTH+1)'(NLEDS);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prime_q, prime_d, count_q, count_d, count_inc;
    logic [NLEDS-1:0] leds_q, leds_d;
    logic             ovf_q, ovf_d, clear;
    assign clear     = (state_q == IDLE) && start;
    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
    always_comb begin
        state_d = state_q;
        prime_d = prime_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                prime_d = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            ISSUE: state_d = GAP;
            GAP:   state_d = WAIT;
            WAIT: if (pg_ready) begin
                if (pg_error) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    prime_d = pg_res;
                    count_d = count_inc;
                    state_d = (limit != '0 && count_inc == limit) ? DONE : ISSUE;
                end
            end
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        leds_d = '0;
        for (int k = 0; k < NLEDS; k++)
            leds_d[k] = !clear && ({1'b0, prime_q} > (WIDTH+1)'(k) * STEP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prime_q <= '0;
            count_q <= '0;
            leds_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
            count_q <= count_d;
            leds_q  <= leds_d;
            ovf_q   <= ovf_d;
        end
    end
`ifdef PRIME_BENCH_CYCLES_EN
    logic [31:0] cycles_q, cycles_d;
    assign cycles_d = clear ? '0 :
                      ((state_q == ISSUE || state_q == GAP || state_q == WAIT) && !(&cycles_q)) ?
                      cycles_q + 32'd1 : cycles_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycles_q <= '0;
        else        cycles_q <= cycles_d;
    end
    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif
    assign pg_go = (state_q == ISSUE);
    assign done  = (state_q == DONE);
    assign prime = prime_q;
    assign count = count_q;
    assign leds  = leds_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_prime_bench_ctrl.sv
// tb_prime_bench_ctrl: randomized bench for prime_bench_ctrl with a behavioural prime generator.
module tb_prime_bench_ctrl;
    logic       clk = 0, rst_n = 1, start = 0, pg_ready = 1, pg_error = 0;
    logic [7:0] limit = 0, pg_res = 0;
    logic       pg_go, done, ovf;
    logic [7:0] prime, count;
    logic [31:0] cycles;
    logic [3:0] leds;
    int checks = 0, failures = 0, go_cnt = 0, lat_max = 4;
    bit hold_gap = 0;
    logic [7:0] gen_q[$];
    int plist[$];

    prime_bench_ctrl #(.WIDTH(8), .NLEDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .pg_go(pg_go),
        .pg_ready(pg_ready), .pg_error(pg_error), .pg_res(pg_res), .prime(prime),
        .count(count), .cycles(cycles), .leds(leds), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] thermo(input int p);
        for (int k = 0; k < 4; k++) thermo[k] = (p > k * 64);
    endfunction

    function automatic bit is_prime(input int p);
        if (p < 2) return 0;
        for (int d = 2; d * d <= p; d++) if (p % d == 0) return 0;
        return 1;
    endfunction

    initial forever begin
        @(posedge clk); #1;
        if (pg_go) go_cnt++;
    end

    // Generator: answers each go after a random latency; an empty queue means overflow.
    initial forever begin
        @(posedge clk); #1;
        if (pg_go) begin
            if (hold_gap) begin
                pg_res = 8'hEE;
                repeat (2) @(posedge clk);
                #1;
            end
            pg_ready = 0;
            repeat ($urandom_range(1, lat_max)) @(posedge clk);
            #1;
            if (gen_q.size() > 0) begin
                pg_res = gen_q.pop_front();
                pg_error = 0;
            end else begin
                pg_res = 8'($urandom);
                pg_error = 1;
            end
            pg_ready = 1;
        end
    end

    task automatic run_to_done(input logic [7:0] lim, output int n);
        int exp_cyc;
        limit = lim;
        start = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 5000);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run_timeout done=%0b required=1", done);
        end
`ifdef PRIME_BENCH_CYCLES_EN
        exp_cyc = n - 1;
`else
        exp_cyc = 0;
`endif
        checks++;
        if (cycles !== 32'(exp_cyc)) begin
            failures++;
            $display("FAIL cycles got=%0d required=%0d", cycles, exp_cyc);
        end
    endtask

    task automatic finish_run();
        start = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({pg_go, prime, count, cycles, leds, done, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {pg_go, prime, count, cycles, leds, done, ovf});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (pg_go !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle go=%0b done=%0b required=0,0", pg_go, done);
        end
    endtask

    task automatic test_limit3();
        int n, g0;
        gen_q = '{8'd2, 8'd3, 8'd5};
        g0 = go_cnt;
        run_to_done(3, n);
        checks++;
        if (prime !== 8'd5 || count !== 8'd3 || ovf !== 1'b0 || go_cnt - g0 != 3) begin
            failures++;
            $display("FAIL limit3 prime=%0d count=%0d ovf=%0b gos=%0d required=5,3,0,3",
                     prime, count, ovf, go_cnt - g0);
        end
        finish_run();
    endtask

    task automatic test_unlimited_overflow();
        int n, g0;
        gen_q.delete();
        foreach (plist[i]) gen_q.push_back(8'(plist[i]));
        g0 = go_cnt;
        run_to_done(0, n);
        checks++;
        if (prime !== 8'd251 || count !== 8'd54 || ovf !== 1'b1 || go_cnt - g0 != 55) begin
            failures++;
            $display("FAIL unlimited prime=%0d count=%0d ovf=%0b gos=%0d required=251,54,1,55",
                     prime, count, ovf, go_cnt - g0);
        end
        @(posedge clk); #1;
        checks++;
        if (leds !== 4'b1111) begin
            failures++;
            $display("FAIL unlimited_leds got=%b required=1111", leds);
        end
        finish_run();
    endtask

    task automatic test_leds_cross();
        int n = 0;
        logic [7:0] prev;
        bit crossed = 0, after = 0;
        gen_q = '{8'd59, 8'd61, 8'd67, 8'd71};
        limit = 4;
        start = 1;
        @(posedge clk); #1;
        prev = prime;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
            checks++;
            if (leds !== thermo(prev)) begin
                failures++;
                $display("FAIL leds_lag prime_prev=%0d got=%b required=%b", prev, leds, thermo(prev));
            end
            if (crossed && !after) begin
                after = 1;
                checks++;
                if (leds !== 4'b0011) begin
                    failures++;
                    $display("FAIL leds_cross_after got=%b required=0011", leds);
                end
            end
            if (prime == 8'd67 && prev != 8'd67) begin
                crossed = 1;
                checks++;
                if (leds !== 4'b0001) begin
                    failures++;
                    $display("FAIL leds_cross_at got=%b required=0001", leds);
                end
            end
            prev = prime;
        end
        checks++;
        if (!after) begin
            failures++;
            $display("FAIL leds_cross_seen got=0 required=1");
        end
        finish_run();
    endtask

    task automatic test_gap_hold();
        int n, g0, k;
        logic [7:0] last;
        hold_gap = 1;
        repeat (3) begin
            k = $urandom_range(1, 5);
            gen_q.delete();
            for (int i = 0; i < k; i++) gen_q.push_back(8'(plist[$urandom_range(0, 53)]));
            last = gen_q[k-1];
            g0 = go_cnt;
            run_to_done(8'(k), n);
            checks++;
            if (prime !== last || count !== 8'(k) || ovf !== 1'b0 || go_cnt - g0 != k) begin
                failures++;
                $display("FAIL gap_hold prime=%0d count=%0d ovf=%0b gos=%0d required=%0d,%0d,0,%0d",
                         prime, count, ovf, go_cnt - g0, last, k, k);
            end
            finish_run();
        end
        hold_gap = 0;
    endtask

    task automatic test_random();
        int n, g0, lim, len, exp_cnt, exp_go;
        logic [7:0] vals[$];
        logic [7:0] exp_prime;
        bit exp_ovf;
        repeat (8) begin
            lim = $urandom_range(0, 6);
            len = $urandom_range(0, 6);
            hold_gap = 1'($urandom_range(0, 1));
            vals.delete();
            for (int i = 0; i < len; i++) vals.push_back(8'(plist[$urandom_range(0, 53)]));
            gen_q = vals;
            if (lim != 0 && len >= lim) begin
                exp_cnt = lim; exp_ovf = 0; exp_go = lim; exp_prime = vals[lim-1];
            end else begin
                exp_cnt = len; exp_ovf = 1; exp_go = len + 1;
                exp_prime = (len > 0) ? vals[len-1] : 8'd0;
            end
            g0 = go_cnt;
            run_to_done(8'(lim), n);
            checks++;
            if (prime !== exp_prime || count !== 8'(exp_cnt) || ovf !== exp_ovf || go_cnt - g0 != exp_go) begin
                failures++;
                $display("FAIL random lim=%0d len=%0d prime=%0d count=%0d ovf=%0b gos=%0d required=%0d,%0d,%0b,%0d",
                         lim, len, prime, count, ovf, go_cnt - g0, exp_prime, exp_cnt, exp_ovf, exp_go);
            end
            finish_run();
            gen_q.delete();
        end
        hold_gap = 0;
    endtask

    task automatic test_back_to_back();
        int n, g0;
        gen_q = '{8'd2, 8'd3, 8'd5};
        run_to_done(3, n);
        g0 = go_cnt;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || go_cnt != g0 || prime !== 8'd5 || count !== 8'd3) begin
            failures++;
            $display("FAIL done_hold done=%0b gos=%0d prime=%0d count=%0d required=1,0,5,3",
                     done, go_cnt - g0, prime, count);
        end
        finish_run();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_release got=%0b required=0", done);
        end
        gen_q = '{8'd7, 8'd11};
        run_to_done(2, n);
        checks++;
        if (count !== 8'd2 || prime !== 8'd11 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL restart count=%0d prime=%0d ovf=%0b required=2,11,0", count, prime, ovf);
        end
        finish_run();
    endtask

    task automatic test_reset_mid();
        int n = 0, g0;
        gen_q = '{8'd13, 8'd17, 8'd19, 8'd23};
        limit = 0;
        start = 1;
        while (!(pg_go && count == 8'd2) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(pg_go && count == 8'd2)) begin
            failures++;
            $display("FAIL reset_mid_reach count=%0d required=2", count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        checks++;
        if ({pg_go, prime, count, cycles, leds, done, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h required=0", {pg_go, prime, count, cycles, leds, done, ovf});
        end
        start = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        g0 = go_cnt;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (go_cnt != g0 || count !== 8'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle gos=%0d count=%0d done=%0b required=0,0,0", go_cnt - g0, count, done);
        end
        gen_q.delete();
    endtask

    initial begin
        for (int p = 2; p < 256; p++) if (is_prime(p)) plist.push_back(p);
        test_reset();
        test_limit3();
        test_unlimited_overflow();
        test_leds_cross();
        test_gap_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
